// File: rtl/sys_key_conditioner_pkg.sv
// Shared defaults and helpers for the key conditioning front end.
// Board timing defaults assume the 50 MHz CLOCK_50.
package sys_key_conditioner_pkg;

    localparam int unsigned DebounceCyclesDefault = 1000000;
    localparam int unsigned AutoHalfDefault       = 12500000;
    localparam int unsigned CntWidthDefault       = 16;

    // Idle levels of the raw inputs: KEYs are active-low, SW_auto is off.
    localparam logic KeyReleased = 1'b1;
    localparam logic SwOff       = 1'b0;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sys_key_conditioner_key_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw input.
// The output changes only after the synchronized input has differed for DEBOUNCE_CYCLES cycles.
module sys_key_conditioner_key_debounce
    import sys_key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter logic        RESET_VAL       = KeyReleased
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= RESET_VAL;
            sync2_q  <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/sys_key_conditioner.sv
// Conditions board KEY/SW inputs into a clean registered step clock, debounced reset,
// optional auto-step square wave and a wrapping step counter.
module sys_key_conditioner
    import sys_key_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned AUTO_HALF       = AutoHalfDefault,
    parameter int unsigned CNT_W           = CntWidthDefault
) (
    input  logic             CLOCK_50,
    input  logic             SYS_rst,
    input  logic             KEY_step_n,
    input  logic             KEY_rst_n,
    input  logic             SW_auto,
    output logic             step_clk,
    output logic             step_pulse,
    output logic             rst_n_clean,
    output logic             auto_mode,
    output logic [CNT_W-1:0] step_count
);

    localparam int unsigned DW = cnt_width(AUTO_HALF);
    localparam logic [DW-1:0] DivMax = DW'(AUTO_HALF - 1);

    logic stable_step_n, stable_rst_n, stable_sw;

    sys_key_conditioner_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (KeyReleased)
    ) u_db_step (
        .clk_i   (CLOCK_50),
        .rst_i   (SYS_rst),
        .raw_i   (KEY_step_n),
        .stable_o(stable_step_n)
    );

    sys_key_conditioner_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (KeyReleased)
    ) u_db_rst (
        .clk_i   (CLOCK_50),
        .rst_i   (SYS_rst),
        .raw_i   (KEY_rst_n),
        .stable_o(stable_rst_n)
    );

    sys_key_conditioner_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_VAL      (SwOff)
    ) u_db_auto (
        .clk_i   (CLOCK_50),
        .rst_i   (SYS_rst),
        .raw_i   (SW_auto),
        .stable_o(stable_sw)
    );

    logic             step_clk_q, step_clk_d;
    logic             step_pulse_q, step_pulse_d;
    logic             rst_n_clean_q;
    logic             auto_mode_q;
    logic [DW-1:0]    div_q, div_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        div_d      = div_q;
        step_clk_d = step_clk_q;
        if (!stable_sw) begin
            div_d      = '0;
            step_clk_d = ~stable_step_n;
        end else if (!auto_mode_q) begin
            // Entering auto mode: restart the half period from a low level.
            div_d      = '0;
            step_clk_d = 1'b0;
        end else if (div_q == DivMax) begin
            div_d      = '0;
            step_clk_d = ~step_clk_q;
        end else begin
            div_d = div_q + 1'b1;
        end
        step_pulse_d = step_clk_d & ~step_clk_q;
        count_d      = step_pulse_d ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (SYS_rst) begin
            step_clk_q    <= 1'b0;
            step_pulse_q  <= 1'b0;
            rst_n_clean_q <= 1'b1;
            auto_mode_q   <= 1'b0;
            div_q         <= '0;
            count_q       <= '0;
        end else begin
            step_clk_q    <= step_clk_d;
            step_pulse_q  <= step_pulse_d;
            rst_n_clean_q <= stable_rst_n;
            auto_mode_q   <= stable_sw;
            div_q         <= div_d;
            count_q       <= count_d;
        end
    end

    assign step_clk    = step_clk_q;
    assign step_pulse  = step_pulse_q;
    assign rst_n_clean = rst_n_clean_q;
    assign auto_mode   = auto_mode_q;
    assign step_count  = count_q;

endmodule

// File: tb/tb_sys_key_conditioner.sv
// Directed bench for sys_key_conditioner with DEBOUNCE_CYCLES=4, AUTO_HALF=3, CNT_W=4.
module tb_sys_key_conditioner;

    logic       CLOCK_50 = 1'b0;
    logic       SYS_rst;
    logic       KEY_step_n;
    logic       KEY_rst_n;
    logic       SW_auto;
    logic       step_clk;
    logic       step_pulse;
    logic       rst_n_clean;
    logic       auto_mode;
    logic [3:0] step_count;

    int n_checks = 0;
    int n_fail   = 0;

    sys_key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_HALF      (3),
        .CNT_W          (4)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .SYS_rst    (SYS_rst),
        .KEY_step_n (KEY_step_n),
        .KEY_rst_n  (KEY_rst_n),
        .SW_auto    (SW_auto),
        .step_clk   (step_clk),
        .step_pulse (step_pulse),
        .rst_n_clean(rst_n_clean),
        .auto_mode  (auto_mode),
        .step_count (step_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    logic [15:0] bounce_pat;
    logic [3:0]  count_exp;
    logic        exp_clk, exp_pulse, exp_mode;

    initial begin
        // Reset held two cycles with every key pressed.
        SYS_rst    = 1'b1;
        KEY_step_n = 1'b0;
        KEY_rst_n  = 1'b0;
        SW_auto    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_clk", step_clk, 0);
            check("rst_pulse", step_pulse, 0);
            check("rst_rstn", rst_n_clean, 1);
            check("rst_cnt", step_count, 0);
            check("rst_auto", auto_mode, 0);
        end
        SYS_rst = 1'b0;
        tick();
        check("post_rst_clk", step_clk, 0);
        check("post_rst_pulse", step_pulse, 0);
        check("post_rst_rstn", rst_n_clean, 1);
        check("post_rst_cnt", step_count, 0);
        KEY_step_n = 1'b1;
        KEY_rst_n  = 1'b1;
        repeat (8) tick();
        check("idle_clk", step_clk, 0);
        check("idle_rstn", rst_n_clean, 1);
        check("idle_cnt", step_count, 0);

        // Clean press: rise 7 cycles after the edge, a single pulse, then release.
        KEY_step_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("press_clk", step_clk, (i >= 7) ? 1 : 0);
            check("press_pulse", step_pulse, (i == 7) ? 1 : 0);
        end
        check("press_cnt", step_count, 1);
        KEY_step_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("release_clk", step_clk, (i < 7) ? 1 : 0);
            check("release_pulse", step_pulse, 0);
        end
        check("release_cnt", step_count, 1);

        // Bounce: low 3, high 1, low 3, then high; shorter than the debounce window.
        bounce_pat = 16'b1111_1111_1000_1000;
        for (int i = 0; i < 16; i++) begin
            KEY_step_n = bounce_pat[i];
            tick();
            check("bounce_clk", step_clk, 0);
            check("bounce_pulse", step_pulse, 0);
        end
        check("bounce_cnt", step_count, 1);

        // Auto mode, ignored key presses, counter wrap, then exit with the key held.
        count_exp = 4'd1;
        SW_auto   = 1'b1;
        for (int t = 1; t <= 135; t++) begin
            if (t == 40)  KEY_step_n = 1'b0;
            if (t == 60)  KEY_step_n = 1'b1;
            if (t == 106) KEY_step_n = 1'b0;
            if (t == 122) SW_auto = 1'b0;
            tick();
            exp_mode  = (t >= 7) && (t <= 127);
            exp_clk   = ((t >= 10) && (t <= 127) && (((t - 10) % 6) < 3)) || (t >= 128);
            exp_pulse = ((t >= 10) && (t <= 127) && (((t - 10) % 6) == 0)) || (t == 128);
            if (exp_pulse) count_exp = count_exp + 4'd1;
            check("auto_mode", auto_mode, exp_mode);
            check("auto_clk", step_clk, exp_clk);
            check("auto_pulse", step_pulse, exp_pulse);
            check("auto_cnt", step_count, count_exp);
        end
        check("exit_cnt", step_count, 6);

        // Reset in the middle of a KEY_rst_n debounce restarts the full latency.
        KEY_step_n = 1'b1;
        KEY_rst_n  = 1'b0;
        repeat (3) tick();
        SYS_rst = 1'b1;
        tick();
        check("mid_rst_clk", step_clk, 0);
        check("mid_rst_pulse", step_pulse, 0);
        check("mid_rst_cnt", step_count, 0);
        check("mid_rst_rstn", rst_n_clean, 1);
        check("mid_rst_auto", auto_mode, 0);
        SYS_rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("rstkey_rstn", rst_n_clean, (i < 7) ? 1 : 0);
            check("rstkey_clk", step_clk, 0);
            check("rstkey_cnt", step_count, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
